// File: rtl/tinyqv_mem_pkg.sv
// Shared definitions for the TinyQV nibble-serial memory responder:
// access size codes, responder state encoding and load-data alignment.
package tinyqv_mem_pkg;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } resp_state_e;

    // Zero-extended, right-aligned load value; the core does any sign extension.
    function automatic logic [31:0] align_read(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] shifted;
        shifted = '0;
        case (size)
            MEM_SIZE_BYTE: begin
                shifted = word >> {off, 3'b000};
                return {24'h0, shifted[7:0]};
            end
            MEM_SIZE_HALF: begin
                shifted = word >> {off[1], 4'b0000};
                return {16'h0, shifted[15:0]};
            end
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/tinyqv_mem_array.sv
// Byte-writable word storage with a registered read port; kept separate so it
// can be replaced by a hard SRAM macro.
module tinyqv_mem_array #(
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic [3:0]           we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [31:0]          wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [31:0]          rdata
);

    logic [31:0] mem [2**ADDR_BITS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tinyqv_mem_responder.sv
// Memory-side responder for the TinyQV nibble-serial load/store interface.
//
//   state | meaning
//   IDLE  | no load outstanding; loads and stores accepted at counter==7
//   WAIT  | load accepted, counting down latency windows
//   SEND  | returning one 8-nibble window with load_data_ready high
module tinyqv_mem_responder
    import tinyqv_mem_pkg::*;
#(
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  counter,
    input  logic [27:0] addr_in,
    input  logic        address_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  mem_op,
    input  logic [3:0]  wdata_in,
    output logic [3:0]  rdata_out,
    output logic        load_data_ready,
    output logic        busy,
    output logic        err
);

    localparam logic [2:0] WAIT_INIT = 3'(LATENCY - 1);

    resp_state_e state_q, state_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        oor_q, oor_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] cap_q, cap_d;

    logic        req, in_range, accept_load, accept_store;
    logic [3:0]  wr_be;
    logic [31:0] wr_data, rd_word, rd_aligned;
    logic        unused_op;

    assign unused_op = mem_op[2];

    assign req          = (counter == 3'd7) && address_ready && (is_load || is_store) && !rst;
    assign in_range     = (addr_in[27:ADDR_BITS+2] == '0);
    assign accept_load  = req && is_load && (state_q == IDLE);
    assign accept_store = req && !is_load && is_store && (state_q == IDLE) && in_range;

    // The committed store word includes the nibble arriving on this edge.
    assign cap_d = {wdata_in, cap_q[31:4]};
    assign err_d = req && ((state_q != IDLE) || !in_range);

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = cap_d;
        if (accept_store) begin
            case (mem_op[1:0])
                MEM_SIZE_BYTE: begin
                    wr_be   = 4'b0001 << addr_in[1:0];
                    wr_data = {4{cap_d[7:0]}};
                end
                MEM_SIZE_HALF: begin
                    wr_be   = addr_in[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{cap_d[15:0]}};
                end
                default: wr_be = 4'b1111;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        size_d     = size_q;
        off_d      = off_q;
        oor_d      = oor_q;
        case (state_q)
            IDLE: begin
                if (accept_load) begin
                    size_d = mem_op[1:0];
                    off_d  = addr_in[1:0];
                    oor_d  = !in_range;
                    if (LATENCY == 1) begin
                        state_d = SEND;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (counter == 3'd7) begin
                    if (wait_cnt_q == 3'd1) state_d = SEND;
                    else                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            SEND: begin
                if (counter == 3'd7) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == SEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            size_q     <= '0;
            off_q      <= '0;
            oor_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            cap_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            size_q     <= size_d;
            off_q      <= off_d;
            oor_q      <= oor_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            cap_q      <= cap_d;
        end
    end

    // Read at acceptance; the word then holds steady until SEND completes.
    tinyqv_mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk   (clk),
        .we    (wr_be),
        .waddr (addr_in[ADDR_BITS+1:2]),
        .wdata (wr_data),
        .re    (accept_load),
        .raddr (addr_in[ADDR_BITS+1:2]),
        .rdata (rd_word)
    );

    assign rd_aligned      = oor_q ? 32'h0 : align_read(rd_word, size_q, off_q);
    assign rdata_out       = ready_q ? rd_aligned[{counter, 2'b00} +: 4] : 4'h0;
    assign load_data_ready = ready_q;
    assign busy            = busy_q;
    assign err             = err_q;

endmodule
